// File: rtl/lcd_clk_sequencer.sv
// LCD clock-domain power-up sequencer: PLL reset/lock, panel reset, wake, run.
// Define LCD_LOCK_RECOVERY_EN to re-sequence on lock loss instead of faulting.
module lcd_clk_sequencer #(
    parameter int unsigned PLL_RST_CYCLES     = 16,
    parameter int unsigned LOCK_STABLE_CYCLES = 1024,
    parameter int unsigned LOCK_TIMEOUT       = 65535,
    parameter int unsigned LCD_RST_CYCLES     = 120,
    parameter int unsigned LCD_WAKE_CYCLES    = 2400,
    parameter int unsigned MAX_RETRIES        = 3
) (
    input  logic       clock_in,
    input  logic       reset_n,
    input  logic       enable,
    input  logic       pll_locked,
    output logic       pll_resetb,
    output logic       lcd_rst_n,
    output logic       lcd_disp_en,
    output logic       ready,
    output logic       fault,
    output logic [2:0] state_o,
    output logic [7:0] lock_loss_cnt
);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_PLL_RST   = 3'd1,
        S_WAIT_LOCK = 3'd2,
        S_LCD_RST   = 3'd3,
        S_LCD_WAKE  = 3'd4,
        S_RUN       = 3'd5,
        S_FAULT     = 3'd6
    } state_t;

    localparam logic [15:0] PLL_LIM   = 16'(PLL_RST_CYCLES);
    localparam logic [15:0] STAB_LIM  = 16'(LOCK_STABLE_CYCLES);
    localparam logic [15:0] TMO_LIM   = 16'(LOCK_TIMEOUT);
    localparam logic [15:0] LRST_LIM  = 16'(LCD_RST_CYCLES);
    localparam logic [15:0] WAKE_LIM  = 16'(LCD_WAKE_CYCLES);
    localparam logic [15:0] RETRY_LIM = 16'(MAX_RETRIES);

    state_t      state_q, state_d;
    logic        sync1_q, sync2_q;
    logic [15:0] cnt_q, cnt_d;
    logic [15:0] stab_q, stab_d;
    logic [15:0] retry_q, retry_d;
    logic [7:0]  loss_q, loss_d;
    logic        pll_resetb_q, pll_resetb_d;
    logic        lcd_rst_n_q, lcd_rst_n_d;
    logic        disp_en_q, disp_en_d;
    logic        ready_q, ready_d;
    logic        fault_q, fault_d;

    logic        lock_s;
    logic        lock_lost;
    logic [15:0] cnt_inc;
    logic [15:0] stab_inc;

    assign lock_s   = sync2_q;
    assign cnt_inc  = cnt_q + 16'd1;
    assign stab_inc = stab_q + 16'd1;

    always_comb begin
        state_d   = state_q;
        retry_d   = retry_q;
        loss_d    = loss_q;
        lock_lost = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (enable) state_d = S_PLL_RST;
            end
            S_PLL_RST: begin
                if (!enable) state_d = S_IDLE;
                else if (cnt_inc == PLL_LIM) state_d = S_WAIT_LOCK;
            end
            S_WAIT_LOCK: begin
                // Lock wins over a timeout landing on the same cycle.
                if (!enable) begin
                    state_d = S_IDLE;
                end else if (lock_s && stab_inc == STAB_LIM) begin
                    state_d = S_LCD_RST;
                end else if (cnt_inc == TMO_LIM) begin
                    if (retry_q < RETRY_LIM) begin
                        retry_d = retry_q + 16'd1;
                        state_d = S_PLL_RST;
                    end else begin
                        state_d = S_FAULT;
                    end
                end
            end
            S_LCD_RST: begin
                if (!enable) state_d = S_IDLE;
                else if (!lock_s) lock_lost = 1'b1;
                else if (cnt_inc == LRST_LIM) state_d = S_LCD_WAKE;
            end
            S_LCD_WAKE: begin
                if (!enable) state_d = S_IDLE;
                else if (!lock_s) lock_lost = 1'b1;
                else if (cnt_inc == WAKE_LIM) state_d = S_RUN;
            end
            S_RUN: begin
                if (!enable) state_d = S_IDLE;
                else if (!lock_s) lock_lost = 1'b1;
            end
            S_FAULT: begin
                if (!enable) state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (lock_lost) begin
            if (loss_q != 8'hFF) loss_d = loss_q + 8'd1;
`ifdef LCD_LOCK_RECOVERY_EN
            state_d = S_PLL_RST;
            retry_d = '0;
`else
            state_d = S_FAULT;
`endif
        end

        if (state_d == S_IDLE || state_d == S_LCD_RST) retry_d = '0;

        // Phase counter restarts on every state change, retries included.
        cnt_d = (state_d != state_q) ? 16'd0 : cnt_inc;

        stab_d = '0;
        if (state_q == S_WAIT_LOCK && state_d == S_WAIT_LOCK && lock_s)
            stab_d = stab_inc;

        pll_resetb_d = 1'b0;
        lcd_rst_n_d  = 1'b0;
        disp_en_d    = 1'b0;
        ready_d      = 1'b0;
        fault_d      = 1'b0;
        unique case (state_d)
            S_WAIT_LOCK, S_LCD_RST: begin
                pll_resetb_d = 1'b1;
            end
            S_LCD_WAKE: begin
                pll_resetb_d = 1'b1;
                lcd_rst_n_d  = 1'b1;
            end
            S_RUN: begin
                pll_resetb_d = 1'b1;
                lcd_rst_n_d  = 1'b1;
                disp_en_d    = 1'b1;
                ready_d      = 1'b1;
            end
            S_FAULT: begin
                fault_d = 1'b1;
            end
            default: begin
                pll_resetb_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clock_in or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= S_IDLE;
            sync1_q      <= 1'b0;
            sync2_q      <= 1'b0;
            cnt_q        <= '0;
            stab_q       <= '0;
            retry_q      <= '0;
            loss_q       <= '0;
            pll_resetb_q <= 1'b0;
            lcd_rst_n_q  <= 1'b0;
            disp_en_q    <= 1'b0;
            ready_q      <= 1'b0;
            fault_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            sync1_q      <= pll_locked;
            sync2_q      <= sync1_q;
            cnt_q        <= cnt_d;
            stab_q       <= stab_d;
            retry_q      <= retry_d;
            loss_q       <= loss_d;
            pll_resetb_q <= pll_resetb_d;
            lcd_rst_n_q  <= lcd_rst_n_d;
            disp_en_q    <= disp_en_d;
            ready_q      <= ready_d;
            fault_q      <= fault_d;
        end
    end

    assign pll_resetb    = pll_resetb_q;
    assign lcd_rst_n     = lcd_rst_n_q;
    assign lcd_disp_en   = disp_en_q;
    assign ready         = ready_q;
    assign fault         = fault_q;
    assign state_o       = state_q;
    assign lock_loss_cnt = loss_q;

endmodule

// File: tb/tb_lcd_clk_sequencer.sv
// Directed bench for lcd_clk_sequencer with small timing parameters.
// Edge 1 in each scenario is the edge that first samples enable high.
module tb_lcd_clk_sequencer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       enable;
    logic       pll_locked;
    logic       pll_resetb;
    logic       lcd_rst_n;
    logic       lcd_disp_en;
    logic       ready;
    logic       fault;
    logic [2:0] state_o;
    logic [7:0] lock_loss_cnt;

    int n_vec = 0;
    int n_err = 0;

    lcd_clk_sequencer #(
        .PLL_RST_CYCLES(4),
        .LOCK_STABLE_CYCLES(8),
        .LOCK_TIMEOUT(32),
        .LCD_RST_CYCLES(4),
        .LCD_WAKE_CYCLES(6),
        .MAX_RETRIES(2)
    ) dut (
        .clock_in(clk),
        .reset_n(rst_n),
        .enable(enable),
        .pll_locked(pll_locked),
        .pll_resetb(pll_resetb),
        .lcd_rst_n(lcd_rst_n),
        .lcd_disp_en(lcd_disp_en),
        .ready(ready),
        .fault(fault),
        .state_o(state_o),
        .lock_loss_cnt(lock_loss_cnt)
    );

    always #5 clk = ~clk;

    // {pll_resetb, lcd_rst_n, lcd_disp_en, ready, fault, state, loss}
    function automatic logic [15:0] pk(logic pr, logic lr, logic de,
                                       logic rd, logic ft,
                                       logic [2:0] st, logic [7:0] lc);
        return {pr, lr, de, rd, ft, st, lc};
    endfunction

    function automatic logic [15:0] obs();
        return {pll_resetb, lcd_rst_n, lcd_disp_en, ready, fault,
                state_o, lock_loss_cnt};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic prep_locked();
        enable     = 1'b0;
        pll_locked = 1'b1;
        repeat (3) tick();
    endtask

    task automatic test_reset();
        rst_n      = 1'b0;
        enable     = 1'b0;
        pll_locked = 1'b0;
        #12;
        n_vec++;
        if (obs() !== pk(0, 0, 0, 0, 0, 3'd0, 8'd0)) begin
            n_err++;
            $display("FAIL reset_outs: got %h want %h", obs(),
                     pk(0, 0, 0, 0, 0, 3'd0, 8'd0));
        end
        tick();
        rst_n = 1'b1;
        tick();
        n_vec++;
        if (state_o !== 3'd0) begin
            n_err++;
            $display("FAIL idle_hold: got %0d want 0", state_o);
        end
    endtask

    task automatic test_nominal();
        logic exp_r;
        prep_locked();
        enable = 1'b1;
        for (int i = 1; i <= 23; i++) begin
            tick();
            exp_r = (i >= 23);
            n_vec++;
            if (ready !== exp_r) begin
                n_err++;
                $display("FAIL nom_ready e%0d: got %b want %b", i, ready, exp_r);
            end
            if (i <= 4 || i == 5) begin
                n_vec++;
                if (pll_resetb !== (i == 5)) begin
                    n_err++;
                    $display("FAIL nom_pllrst e%0d: got %b want %b",
                             i, pll_resetb, (i == 5));
                end
            end
            if (i >= 13 && i <= 17) begin
                n_vec++;
                if (lcd_rst_n !== (i == 17)) begin
                    n_err++;
                    $display("FAIL nom_lcdrst e%0d: got %b want %b",
                             i, lcd_rst_n, (i == 17));
                end
            end
        end
        n_vec++;
        if (obs() !== pk(1, 1, 1, 1, 0, 3'd5, 8'd0)) begin
            n_err++;
            $display("FAIL nom_run: got %h want %h", obs(),
                     pk(1, 1, 1, 1, 0, 3'd5, 8'd0));
        end
    endtask

    task automatic test_lock_glitch();
        logic exp_r;
        prep_locked();
        enable = 1'b1;
        for (int i = 1; i <= 29; i++) begin
            tick();
            // Low at edge 9 -> synchronised low only for edge 11.
            if (i == 8) pll_locked = 1'b0;
            if (i == 9) pll_locked = 1'b1;
            exp_r = (i >= 29);
            n_vec++;
            if (ready !== exp_r) begin
                n_err++;
                $display("FAIL glitch_ready e%0d: got %b want %b", i, ready, exp_r);
            end
            if (i == 13 || i == 19) begin
                n_vec++;
                if (state_o !== ((i == 13) ? 3'd2 : 3'd3)) begin
                    n_err++;
                    $display("FAIL glitch_state e%0d: got %0d want %0d",
                             i, state_o, (i == 13) ? 2 : 3);
                end
            end
        end
    endtask

    task automatic test_enable_drop();
        enable = 1'b0;
        tick();
        n_vec++;
        if (obs() !== pk(0, 0, 0, 0, 0, 3'd0, 8'd0)) begin
            n_err++;
            $display("FAIL en_drop: got %h want %h", obs(),
                     pk(0, 0, 0, 0, 0, 3'd0, 8'd0));
        end
    endtask

    task automatic test_no_lock();
        logic exp_pr;
        logic prev;
        int   rises;
        enable     = 1'b0;
        pll_locked = 1'b0;
        repeat (3) tick();
        enable = 1'b1;
        rises  = 0;
        prev   = pll_resetb;
        for (int i = 1; i <= 114; i++) begin
            tick();
            if (!prev && pll_resetb) rises++;
            prev = pll_resetb;
            exp_pr = !((i <= 4) || (i >= 37 && i <= 40) ||
                       (i >= 73 && i <= 76) || (i >= 109));
            n_vec++;
            if (pll_resetb !== exp_pr) begin
                n_err++;
                $display("FAIL nolock_pll e%0d: got %b want %b",
                         i, pll_resetb, exp_pr);
            end
            n_vec++;
            if (fault !== (i >= 109)) begin
                n_err++;
                $display("FAIL nolock_fault e%0d: got %b want %b",
                         i, fault, (i >= 109));
            end
        end
        n_vec++;
        if (rises !== 3) begin
            n_err++;
            $display("FAIL nolock_pulses: got %0d want 3", rises);
        end
        n_vec++;
        if (obs() !== pk(0, 0, 0, 0, 1, 3'd6, 8'd0)) begin
            n_err++;
            $display("FAIL nolock_state: got %h want %h", obs(),
                     pk(0, 0, 0, 0, 1, 3'd6, 8'd0));
        end
        enable = 1'b0;
        tick();
        n_vec++;
        if (obs() !== pk(0, 0, 0, 0, 0, 3'd0, 8'd0)) begin
            n_err++;
            $display("FAIL nolock_exit: got %h want %h", obs(),
                     pk(0, 0, 0, 0, 0, 3'd0, 8'd0));
        end
    endtask

    task automatic test_lock_loss();
        prep_locked();
        enable = 1'b1;
        repeat (23) tick();
        n_vec++;
        if (ready !== 1'b1) begin
            n_err++;
            $display("FAIL loss_pre: got %b want 1", ready);
        end
        pll_locked = 1'b0;
        for (int i = 1; i <= 2; i++) begin
            tick();
            n_vec++;
            if (ready !== 1'b1) begin
                n_err++;
                $display("FAIL loss_sync e%0d: got %b want 1", i, ready);
            end
        end
        tick();
`ifdef LCD_LOCK_RECOVERY_EN
        n_vec++;
        if (obs() !== pk(0, 0, 0, 0, 0, 3'd1, 8'd1)) begin
            n_err++;
            $display("FAIL loss_recover: got %h want %h", obs(),
                     pk(0, 0, 0, 0, 0, 3'd1, 8'd1));
        end
        pll_locked = 1'b1;
        for (int i = 4; i <= 25; i++) begin
            tick();
            n_vec++;
            if (ready !== (i >= 25)) begin
                n_err++;
                $display("FAIL loss_reseq e%0d: got %b want %b",
                         i, ready, (i >= 25));
            end
        end
`else
        n_vec++;
        if (obs() !== pk(0, 0, 0, 0, 1, 3'd6, 8'd1)) begin
            n_err++;
            $display("FAIL loss_fault: got %h want %h", obs(),
                     pk(0, 0, 0, 0, 1, 3'd6, 8'd1));
        end
        pll_locked = 1'b1;
        repeat (4) tick();
        n_vec++;
        if (fault !== 1'b1) begin
            n_err++;
            $display("FAIL loss_sticky: got %b want 1", fault);
        end
`endif
        enable = 1'b0;
        tick();
        n_vec++;
        if (obs() !== pk(0, 0, 0, 0, 0, 3'd0, 8'd1)) begin
            n_err++;
            $display("FAIL loss_exit: got %h want %h", obs(),
                     pk(0, 0, 0, 0, 0, 3'd0, 8'd1));
        end
    endtask

    task automatic test_reset_mid_wake();
        prep_locked();
        enable = 1'b1;
        repeat (18) tick();
        n_vec++;
        if (obs() !== pk(1, 1, 0, 0, 0, 3'd4, 8'd1)) begin
            n_err++;
            $display("FAIL wake_pre: got %h want %h", obs(),
                     pk(1, 1, 0, 0, 0, 3'd4, 8'd1));
        end
        #2;
        rst_n = 1'b0;
        #1;
        n_vec++;
        if (obs() !== pk(0, 0, 0, 0, 0, 3'd0, 8'd0)) begin
            n_err++;
            $display("FAIL wake_rst: got %h want %h", obs(),
                     pk(0, 0, 0, 0, 0, 3'd0, 8'd0));
        end
        tick();
        rst_n = 1'b1;
        n_vec++;
        if (state_o !== 3'd0) begin
            n_err++;
            $display("FAIL rel_hold: got %0d want 0", state_o);
        end
        tick();
        n_vec++;
        if (obs() !== pk(0, 0, 0, 0, 0, 3'd1, 8'd0)) begin
            n_err++;
            $display("FAIL rel_step: got %h want %h", obs(),
                     pk(0, 0, 0, 0, 0, 3'd1, 8'd0));
        end
        enable = 1'b0;
        tick();
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_lock_glitch();
        test_enable_drop();
        test_no_lock();
        test_lock_loss();
        test_reset_mid_wake();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/lcd_clk_sequencer.md
LCD_CLK_SEQUENCER -- requirements
Module: lcd_clk_sequencer

Interface
REQ-001 SHALL have parameter PLL_RST_CYCLES, default 16: cycles pll_resetb is held low per lock attempt.
REQ-002 SHALL have parameter LOCK_STABLE_CYCLES, default 1024: consecutive pll_locked-high cycles required to declare lock.
REQ-003 SHALL have parameter LOCK_TIMEOUT, default 65535: cycles allowed in WAIT_LOCK per attempt.
REQ-004 SHALL have parameter LCD_RST_CYCLES, default 120: cycles lcd_rst_n is held low.
REQ-005 SHALL have parameter LCD_WAKE_CYCLES, default 2400: cycles from lcd_rst_n release to display enable.
REQ-006 SHALL have parameter MAX_RETRIES, default 3: lock retries after the first attempt before FAULT.
REQ-007 SHALL have port clock_in, input, 1: single free-running clock; all logic is on its rising edge.
REQ-008 SHALL have port reset_n, input, 1: asynchronous active-low reset.
REQ-009 SHALL have port enable, input, 1: level request to power up the LCD clock domain.
REQ-010 SHALL have port pll_locked, input, 1: PLL LOCK; treated as asynchronous and passed through a 2-flop synchroniser before any use.
REQ-011 SHALL have port pll_resetb, output, 1: drives PLL RESETB; low means PLL held in reset.
REQ-012 SHALL have port lcd_rst_n, output, 1: LCD panel reset, active-low.
REQ-013 SHALL have port lcd_disp_en, output, 1: LCD display enable.
REQ-014 SHALL have port ready, output, 1: high only in RUN.
REQ-015 SHALL have port fault, output, 1: high only in FAULT.
REQ-016 SHALL have port state_o, output, 3: current state encoding for debug.
REQ-017 SHALL have port lock_loss_cnt, output, 8: saturating count of lock losses after lock was declared.

Function
REQ-018 SHALL implement states IDLE, PLL_RST, WAIT_LOCK, LCD_RST, LCD_WAKE, RUN, FAULT; all outputs registered, changing on the edge the state changes.
REQ-019 IDLE: pll_resetb=0, lcd_rst_n=0, lcd_disp_en=0, ready=0; enable=1 -> PLL_RST.
REQ-020 PLL_RST: pll_resetb=0 for exactly PLL_RST_CYCLES cycles -> WAIT_LOCK.
REQ-021 WAIT_LOCK: pll_resetb=1; stability counter increments while synchronised lock=1 and clears on any 0 cycle; reaching LOCK_STABLE_CYCLES -> LCD_RST.
REQ-022 WAIT_LOCK timeout counter starts at entry; reaching LOCK_TIMEOUT with retries<MAX_RETRIES -> retries+1, PLL_RST; otherwise -> FAULT.
REQ-023 Stability reached and timeout reached in the same cycle SHALL resolve as lock (-> LCD_RST).
REQ-024 LCD_RST: lcd_rst_n=0 for LCD_RST_CYCLES -> LCD_WAKE; retry count cleared on entry.
REQ-025 LCD_WAKE: lcd_rst_n=1 for LCD_WAKE_CYCLES -> RUN.
REQ-026 RUN: lcd_rst_n=1, lcd_disp_en=1, ready=1.
REQ-027 With lock held high, ready SHALL rise exactly 1+PLL_RST_CYCLES+LOCK_STABLE_CYCLES+LCD_RST_CYCLES+LCD_WAKE_CYCLES edges after enable is first sampled high (synchroniser latency excluded).
REQ-028 Synchronised lock=0 in LCD_RST, LCD_WAKE or RUN SHALL increment lock_loss_cnt (saturate at 255) and take the Configuration-defined action.
REQ-029 enable=0 in any state SHALL -> IDLE next edge, overriding lock loss and timeout; FAULT exits only via enable=0 or reset.
REQ-030 Cycle counters SHALL be 16 bits; parameters SHALL be 1..65535.

Reset
REQ-031 reset_n low SHALL immediately force IDLE, pll_resetb=0, lcd_rst_n=0, lcd_disp_en=0, ready=0, fault=0, lock_loss_cnt=0, all counters and synchroniser flops 0.
REQ-032 Release of reset_n SHALL take effect on the next clock_in edge; no state advances on the release edge itself.

Configuration
REQ-033 Macro LCD_LOCK_RECOVERY_EN defined: lock loss per REQ-028 -> PLL_RST with retries cleared, lcd_disp_en and ready dropping on the same edge.
REQ-034 LCD_LOCK_RECOVERY_EN undefined: lock loss per REQ-028 -> FAULT (pll_resetb=0, lcd_rst_n=0, lcd_disp_en=0, fault=1).

Verification (PLL_RST_CYCLES=4, LOCK_STABLE_CYCLES=8, LOCK_TIMEOUT=32, LCD_RST_CYCLES=4, LCD_WAKE_CYCLES=6, MAX_RETRIES=2)
REQ-035 Locked tied 1, enable raised -> ready high exactly 23 edges after enable sampled (+2 sync); pll_resetb low 4 cycles; lcd_rst_n low 4 cycles.
REQ-036 Lock drops 1 cycle at stability count 5 -> count restarts; ready delayed by exactly 6 cycles versus REQ-035.
REQ-037 Lock never asserts -> 3 pll_resetb low pulses of 4 cycles each, then fault=1, state_o=FAULT; enable=0 -> IDLE.
REQ-038 Lock drops in RUN, LCD_LOCK_RECOVERY_EN defined -> ready=0 next edge, lock_loss_cnt=1, ready returns after a full re-sequence; undefined -> fault=1.
REQ-039 reset_n pulsed low mid-LCD_WAKE -> all outputs at reset values before next edge, lock_loss_cnt=0.
REQ-040 enable dropped in RUN -> IDLE next edge, pll_resetb=0, lcd_disp_en=0, ready=0.
